// File: rtl/mutex_pkg.sv
// Shared types and constants for the 3-node mutual-exclusion rule system.
// Node states, rule-type indices and the default node count.
package mutex_pkg;

  localparam int STATE_W   = 2;
  localparam int NUM_RULES = 4;
  localparam int NODES_DEF = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_I = 2'b00,
    ST_T = 2'b01,
    ST_C = 2'b10,
    ST_E = 2'b11
  } state_e;

  localparam int TRY  = 0;
  localparam int CRIT = 1;
  localparam int EXIT = 2;
  localparam int IDLE = 3;

endpackage

// File: rtl/mutex_rule_decode.sv
// Maps a rule index (rule*NODES + node) to a one-hot fire vector.
// Indices at or beyond NUM_RULES*NODES match no entry and give all zeros.
module mutex_rule_decode
  import mutex_pkg::*;
#(
  parameter int NODES = NODES_DEF,
  parameter int IDX_W = $clog2(NUM_RULES*NODES)
) (
  input  logic [IDX_W-1:0]                idx_i,
  output logic [NUM_RULES-1:0][NODES-1:0] fire_o
);

  for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
    for (genvar i = 0; i < NODES; i++) begin : g_node
      localparam int K = r*NODES + i;
      assign fire_o[r][i] = (idx_i == IDX_W'(K));
    end
  end

endmodule

// File: rtl/mutex_rule_system.sv
// Murphi mutex protocol: per-node state n[i], shared token x, one guarded rule per clock.
// State registers keep fixed names so the formal flow can reach them hierarchically.
module mutex_rule_system
  import mutex_pkg::*;
#(
  parameter  int NODES = NODES_DEF,
  localparam int IDX_W = $clog2(NUM_RULES*NODES)
) (
  input logic             clock,
  input logic             reset,
  input logic [IDX_W-1:0] io_en_a
);

  state_e n_reg_0, n_reg_1, n_reg_2;
  logic   x_reg;

  logic [NUM_RULES-1:0][NODES-1:0] fire;
  logic [NODES-1:0][STATE_W-1:0]   n_cur, n_nxt;
  logic                            x_d;
  logic [NODES-1:0]                is_c, is_ce;

  mutex_rule_decode #(.NODES(NODES), .IDX_W(IDX_W)) u_dec (
    .idx_i  (io_en_a),
    .fire_o (fire)
  );

  // Register names are fixed per node, so the array view is built by hand.
  assign n_cur = {n_reg_2, n_reg_1, n_reg_0};

  // At most one fire bit is set, so the x updates never collide.
  always_comb begin
    n_nxt = n_cur;
    x_d   = x_reg;
    for (int i = 0; i < NODES; i++) begin
      if (fire[TRY][i] && n_cur[i] == ST_I) n_nxt[i] = ST_T;
      if (fire[CRIT][i] && n_cur[i] == ST_T && x_reg) begin
        n_nxt[i] = ST_C;
        x_d      = 1'b0;
      end
      if (fire[EXIT][i] && n_cur[i] == ST_C) n_nxt[i] = ST_E;
      if (fire[IDLE][i] && n_cur[i] == ST_E) begin
        n_nxt[i] = ST_I;
        x_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_reg_0 <= ST_I;
      n_reg_1 <= ST_I;
      n_reg_2 <= ST_I;
      x_reg   <= 1'b1;
    end else begin
      n_reg_0 <= state_e'(n_nxt[0]);
      n_reg_1 <= state_e'(n_nxt[1]);
      n_reg_2 <= state_e'(n_nxt[2]);
      x_reg   <= x_d;
    end
  end

  always_comb begin
    is_c  = '0;
    is_ce = '0;
    for (int i = 0; i < NODES; i++) begin
      is_c[i]  = (n_cur[i] == ST_C);
      is_ce[i] = (n_cur[i] == ST_C) || (n_cur[i] == ST_E);
    end
  end

  a_one_crit: assert property (@(posedge clock) disable iff (reset)
    $countones(is_c) <= 1);
  a_one_owner: assert property (@(posedge clock) disable iff (reset)
    $countones(is_ce) <= 1);
  a_token: assert property (@(posedge clock) disable iff (reset)
    x_reg == (is_ce == '0));

endmodule

// File: tb/tb_mutex_rule_system.sv
// Directed protocol scenarios followed by random rule selection with
// occasional async reset pulses, checked against a rule-level model.
module tb_mutex_rule_system;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] io_en_a = 4'd0;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_n [3];
  logic       m_x;

  mutex_rule_system dut (
    .clock   (clock),
    .reset   (reset),
    .io_en_a (io_en_a)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model_vec();
    return {m_n[2], m_n[1], m_n[0], m_x};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {dut.n_reg_2, dut.n_reg_1, dut.n_reg_0, dut.x_reg};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_n[i] = 2'b00;
    m_x = 1'b1;
  endtask

  // I=0 T=1 C=2 E=3; rule = idx/3, node = idx%3, idx >= 12 is a no-op.
  task automatic model_apply(input int idx);
    int r, i;
    if (idx < 12) begin
      r = idx / 3;
      i = idx % 3;
      case (r)
        0: if (m_n[i] == 2'd0) m_n[i] = 2'd1;
        1: if (m_n[i] == 2'd1 && m_x) begin m_n[i] = 2'd2; m_x = 1'b0; end
        2: if (m_n[i] == 2'd2) m_n[i] = 2'd3;
        default: if (m_n[i] == 2'd3) begin m_n[i] = 2'd0; m_x = 1'b1; end
      endcase
    end
  endtask

  task automatic step(input int idx, input string tag);
    @(negedge clock);
    io_en_a = 4'(idx);
    @(posedge clock);
    #1;
    model_apply(idx);
    chk(tag, 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset   = 1'b1;
    io_en_a = 4'($urandom_range(0, 15));
    model_reset();
    @(posedge clock);
    #1;
    chk(tag, 32'(dut_vec()), 32'(model_vec()));
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    io_en_a = 4'd5;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", 32'(dut_vec()), 32'h01);
    @(negedge clock);
    reset = 1'b0;

    step(2, "preload_n2");
    chk("preload_n2_T", 32'(dut.n_reg_2), 32'd1);
    do_reset("reset_clears_preload");
    chk("n2_cleared", 32'(dut.n_reg_2), 32'd0);

    step(2, "try_n2");
    chk("try_n2_T", 32'(dut.n_reg_2), 32'd1);
    step(0, "try_n0");
    chk("try_n0_T", 32'(dut.n_reg_0), 32'd1);

    do_reset("reset_before_cycle");
    step(1, "cyc_try");
    chk("cyc_try_nx", 32'({dut.n_reg_1, dut.x_reg}), 32'({2'd1, 1'b1}));
    step(4, "cyc_crit");
    chk("cyc_crit_nx", 32'({dut.n_reg_1, dut.x_reg}), 32'({2'd2, 1'b0}));
    step(7, "cyc_exit");
    chk("cyc_exit_nx", 32'({dut.n_reg_1, dut.x_reg}), 32'({2'd3, 1'b0}));
    step(10, "cyc_idle");
    chk("cyc_idle_nx", 32'({dut.n_reg_1, dut.x_reg}), 32'({2'd0, 1'b1}));

    do_reset("reset_before_excl");
    step(0, "excl_try0");
    step(1, "excl_try1");
    step(3, "excl_crit0");
    step(4, "excl_crit1_blocked");
    chk("excl_n1_T_x0", 32'({dut.n_reg_1, dut.x_reg}), 32'({2'd1, 1'b0}));

    do_reset("reset_before_noop");
    step(6, "exit_guard_false");
    chk("exit_guard_n0_I", 32'(dut.n_reg_0), 32'd0);
    step(1, "noop_setup");
    step(4, "noop_setup2");
    for (int k = 12; k < 16; k++) step(k, "noop_idx");

    do_reset("reset_before_async");
    step(0, "async_try0");
    step(3, "async_crit0");
    @(negedge clock);
    io_en_a = 4'd6;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_immediate", 32'(dut_vec()), 32'h01);
    @(posedge clock);
    #1;
    chk("async_reset_held", 32'(dut_vec()), 32'h01);
    @(negedge clock);
    reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rand_reset");
      else step(int'($urandom_range(0, 15)), "rand_step");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
